sram_like_resp: RTL and testbench

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

---
 rtl/sram_like_resp.sv | 113 +++++++++++
 tb/tb_sram_like_resp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// SRAM-like slave front end: in-order responses with up to OUTSTANDING requests in flight.
// Define SRAM_LIKE_RESP_STALL_EN to add LFSR-driven pseudo-random address/data stalls.
module sram_like_resp #(
    parameter int          OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam logic [2:0] OUT_MAX = 3'(OUTSTANDING);
    localparam logic [1:0] PTR_MAX = 2'(OUTSTANDING - 1);

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == PTR_MAX) ? 2'd0 : p + 2'd1;
    endfunction

    logic        vld_p1;
    logic        wr_p1;
    logic        reset_q;
    logic [31:0] mem [0:3];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  fcnt;
    logic [2:0]  inflight;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        astall;
    logic        dstall;
    logic [31:0] resp_p1;
    logic        unused_ok;

    assign unused_ok = ^{size, addr[1:0]};

`ifdef SRAM_LIKE_RESP_STALL_EN
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign astall = (lfsr[1:0] == 2'b11);
    assign dstall = (lfsr[3:2] == 2'b11);
`else
    localparam logic [15:0] UNUSED_SEED = LFSR_SEED;
    assign astall = 1'b0;
    assign dstall = 1'b0;
`endif

    // In flight = answered-next-cycle stage plus whatever waits in the FIFO.
    assign inflight   = fcnt + {2'b00, vld_p1};
    assign fifo_empty = (fcnt == 3'd0);
    assign data_ok    = !reset && !dstall && (vld_p1 || !fifo_empty);
    // A same-cycle response frees a slot, so a full block can still accept.
    assign addr_ok    = !reset && !reset_q && !astall && ((inflight < OUT_MAX) || data_ok);
    assign accept     = req && addr_ok;

    assign ram_en    = accept;
    assign ram_wen   = (accept && wr) ? wstrb : 4'h0;
    assign ram_addr  = {addr[31:2], 2'b00};
    assign ram_wdata = wdata;

    assign resp_p1 = wr_p1 ? 32'h0 : ram_rdata;
    assign pop     = data_ok && !fifo_empty;
    assign push    = vld_p1 && !(data_ok && fifo_empty);
    assign rdata   = !data_ok ? 32'h0 : (fifo_empty ? resp_p1 : mem[rd_ptr]);

    // p0 -> p1: accepted request waits one cycle for the SRAM read data
    always_ff @(posedge clk) begin
        reset_q <= reset;
        wr_p1   <= wr;
        if (reset) begin
            vld_p1 <= 1'b0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            fcnt   <= 3'd0;
        end else begin
            vld_p1 <= accept;
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 3'd1;
                2'b01:   fcnt <= fcnt - 3'd1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    // p1 -> FIFO: responses that cannot bypass are parked in order
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= resp_p1;
    end
endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: directed vector table, hand sequences and a randomized queue-model check.
module tb_sram_like_resp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        addr_ok, data_ok, ram_en;
    logic [31:0] rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_wen;
    logic [31:0] ram_rdata = 32'h0;

    logic        req1 = 1'b0;
    logic [31:0] addr1 = 32'h0;
    logic        addr_ok1, data_ok1, ram_en1;
    logic [31:0] rdata1, ram_addr1, ram_wdata1;
    logic [3:0]  ram_wen1;
    logic [31:0] ram_rdata1 = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [31:0] sram_mem [0:255];

    always #5 clk = ~clk;

    sram_like_resp u_dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    sram_like_resp #(.OUTSTANDING(1)) u_one (
        .clk(clk), .reset(reset), .req(req1), .wr(1'b0), .size(2'd2), .wstrb(4'h0),
        .addr(addr1), .wdata(32'h0), .addr_ok(addr_ok1), .data_ok(data_ok1), .rdata(rdata1),
        .ram_en(ram_en1), .ram_wen(ram_wen1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural synchronous SRAMs
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen == 4'h0) ram_rdata <= sram_mem[ram_addr[9:2]];
            else sram_mem[ram_addr[9:2]] <= merge(sram_mem[ram_addr[9:2]], ram_wdata, ram_wen);
        end
        if (ram_en1) ram_rdata1 <= ram_addr1 ^ 32'h5A5A_5A5A;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_addr_ok;
        logic        e_data_ok;
        logic [31:0] e_rdata;
        logic        e_ram_en;
        logic [3:0]  e_ram_wen;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] exp_q[$];
    logic [31:0] q1[$];

    initial begin
        logic acc, acc_prev;
        int   cnt_before;
        for (int i = 0; i < 256; i++) sram_mem[i] = 32'hC0DE_0000 | i;
        sram_mem[1] = 32'h2402_0001;

        //            rst  req  wr   strb  addr          wdata         aok  dok  rdata         en   wen
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h1FC00004, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 4'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h1FC00004, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 4'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h00000010, 32'hDEADBEEF, 1'b1, 1'b1, 32'h24020001, 1'b1, 4'h3};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 4'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h00000013, 32'h12345678, 1'b1, 1'b0, 32'h0,        1'b1, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hC0DEBEEF, 1'b0, 4'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h00000020, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 4'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 4'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h00000024, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 4'h0};

        repeat (2) @(posedge clk);

`ifndef SRAM_LIKE_RESP_STALL_EN
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst; req = vecs[i].req; wr = vecs[i].wr;
            wstrb = vecs[i].wstrb; addr = vecs[i].addr; wdata = vecs[i].wdata;
            @(negedge clk);
            check($sformatf("vec%0d_addr_ok", i), addr_ok, vecs[i].e_addr_ok);
            check($sformatf("vec%0d_data_ok", i), data_ok, vecs[i].e_data_ok);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
            check($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].e_ram_en);
            check($sformatf("vec%0d_ram_wen", i), ram_wen, vecs[i].e_ram_wen);
            if (vecs[i].e_ram_en) check($sformatf("vec%0d_ram_addr", i), ram_addr,
                                        {vecs[i].addr[31:2], 2'b00});
        end

        // Eight back-to-back reads of consecutive words
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            req = (k < 8); wr = 1'b0; addr = 32'h40 + 32'(4 * k);
            @(negedge clk);
            if (k < 8) check($sformatf("b2b_addr_ok%0d", k), addr_ok, 1'b1);
            if (k >= 1) begin
                check($sformatf("b2b_data_ok%0d", k), data_ok, 1'b1);
                check($sformatf("b2b_rdata%0d", k), rdata, 32'hC0DE_0000 | 32'(16 + k - 1));
            end
        end
        @(posedge clk); #1; req = 1'b0;
`else
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("rst_addr_ok", addr_ok, 1'b0);
        check("rst_data_ok", data_ok, 1'b0);
        check("rst_ram_en", ram_en, 1'b0);
        @(posedge clk); #1; reset = 1'b0;
`endif

        // OUTSTANDING=1 instance with req held high
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            req1 = 1'b1; addr1 = 32'(4 * i);
            @(negedge clk);
            acc = req1 && addr_ok1;
            if (data_ok1) begin
                if (q1.size() == 0) check("one_spurious_data_ok", 32'd1, 32'd0);
                else check("one_rdata", rdata1, q1.pop_front());
`ifndef SRAM_LIKE_RESP_STALL_EN
                check("one_acc_with_dok", addr_ok1, 1'b1);
`endif
            end
            if (acc) q1.push_back({addr1[31:2], 2'b00} ^ 32'h5A5A_5A5A);
            check("one_count_le1", 32'(q1.size() <= 1), 32'd1);
        end
        for (int i = 0; i < 30 && q1.size() != 0; i++) begin
            @(posedge clk); #1; req1 = 1'b0;
            @(negedge clk);
            if (data_ok1) check("one_drain_rdata", rdata1, q1.pop_front());
        end
        @(posedge clk); #1; req1 = 1'b0;
        check("one_drained", 32'(q1.size()), 32'd0);

        // Randomized traffic against an in-order response queue
        acc_prev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            req = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 3) == 0);
            wstrb = 4'($urandom);
            addr = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom)};
            wdata = $urandom;
            @(negedge clk);
            acc = req && addr_ok;
            cnt_before = exp_q.size();
`ifndef SRAM_LIKE_RESP_STALL_EN
            check("rnd_latency", data_ok, acc_prev);
`endif
            if (cnt_before == 2 && !data_ok) check("rnd_full_addr_ok", addr_ok, 1'b0);
            if (data_ok) begin
                if (exp_q.size() == 0) check("rnd_spurious_data_ok", 32'd1, 32'd0);
                else check("rnd_rdata", rdata, exp_q.pop_front());
            end
            check("rnd_ram_en", ram_en, acc);
            check("rnd_ram_wen", ram_wen, (acc && wr) ? wstrb : 4'h0);
            if (acc) exp_q.push_back(wr ? 32'h0 : sram_mem[addr[9:2]]);
            check("rnd_count_le2", 32'(exp_q.size() <= 2), 32'd1);
            acc_prev = acc;
        end
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1; req = 1'b0;
            @(negedge clk);
            if (data_ok) check("rnd_drain_rdata", rdata, exp_q.pop_front());
        end
        check("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
